// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM request
// and holds a redirect that arrives while the PC is frozen.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'hbfbf_fffc,
  parameter int          STALL_W     = 6,
  parameter int          BR_WD       = 33,
  parameter int          IF_TO_ID_WD = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  output logic                   fetch_adel
);

  localparam logic STOP = 1'b1;

  logic        br_e;
  logic [31:0] br_addr;
  logic        stop;

  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] next_pc;
  logic        aligned;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign stop    = (stall[0] == STOP);

  // A held redirect outranks whatever ID is showing now: ID is stalled on the
  // same branch, so the first captured target is the correct one.
  always_comb begin
    next_pc = pc_reg + 32'h4;
    if (pend_v)
      next_pc = pend_addr;
    else if (br_e)
      next_pc = br_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'h0;
    end else if (!stop) begin
      pc_reg <= next_pc;
      ce_reg <= 1'b1;
      pend_v <= 1'b0;
    end else if (br_e && !pend_v) begin
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end
  end

  // Outputs depend only on registered state.
  assign aligned         = (pc_reg[1:0] == 2'b00);
  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_en    = ce_reg & aligned;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign fetch_adel      = ce_reg & ~aligned;

endmodule
